// File: rtl/gate_pkg.sv
// Shared definitions for the 2-input gate BIST: opcodes, FSM encoding and
// the truth-table function used by both the controller and golden models.
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_LAST = OP_XNOR;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } bist_state_t;

  function automatic logic gate_expected(input logic [2:0] op, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// Handshake/result bundle between the BIST controller and its user/gate.
interface gate_bist_ctrl_if;
  logic       start;
  logic [2:0] op;
  logic       y;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [2:0] fail_count;
  logic       op_err;

  modport master (
    output start, op, y,
    input  a, b, busy, done, pass, fail_mask, fail_count, op_err
  );

  modport slave (
    input  start, op, y,
    output a, b, busy, done, pass, fail_mask, fail_count, op_err
  );
endinterface

// File: rtl/gate_ref_model.sv
// Combinational golden model of the selected 2-input gate.
module gate_ref_model
  import gate_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y_exp
);
  assign y_exp = gate_expected(op, a, b);
endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: walks a 2-input gate through 00,01,10,11, settles each
// vector SETTLE_CYCLES clocks, checks y against the truth table.
module gate_bist_ctrl
  import gate_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  gate_bist_ctrl_if.slave bus
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  bist_state_t state_q, state_d;
  logic [1:0]  vec_q, vec_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  ab_q, ab_d;
  logic [3:0]  mask_q, mask_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic        pass_q, pass_d;
  logic        operr_q, operr_d;
  logic        y_exp;

  gate_ref_model u_ref (
    .op    (op_q),
    .a     (vec_q[1]),
    .b     (vec_q[0]),
    .y_exp (y_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      ab_q    <= 2'd0;
      mask_q  <= 4'd0;
      fcnt_q  <= 3'd0;
      pass_q  <= 1'b0;
      operr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ab_q    <= ab_d;
      mask_q  <= mask_d;
      fcnt_q  <= fcnt_d;
      pass_q  <= pass_d;
      operr_q <= operr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ab_d    = ab_q;
    mask_d  = mask_q;
    fcnt_d  = fcnt_q;
    pass_d  = pass_q;
    operr_d = operr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.op <= OP_LAST) begin
            op_d    = bus.op;
            vec_d   = 2'd0;
            cnt_d   = 4'd0;
            ab_d    = 2'd0;
            mask_d  = 4'd0;
            fcnt_d  = 3'd0;
            pass_d  = 1'b0;
            operr_d = 1'b0;
            state_d = ST_SETTLE;
          end else begin
            // Illegal op: report every vector failed and skip the walk.
            operr_d = 1'b1;
            mask_d  = 4'b1111;
            fcnt_d  = 3'd4;
            pass_d  = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 4'd0;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_CHECK: begin
        if (bus.y != y_exp) begin
          mask_d[vec_q] = 1'b1;
          fcnt_d        = fcnt_q + 3'd1;
        end
        if (vec_q == 2'd3) begin
          // pass must include this final compare, so use the next count.
          pass_d  = (fcnt_d == 3'd0) && !operr_q;
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 2'd1;
          ab_d    = vec_q + 2'd1;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.a          = ab_q[1];
  assign bus.b          = ab_q[0];
  assign bus.busy       = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.pass       = pass_q;
  assign bus.fail_mask  = mask_q;
  assign bus.fail_count = fcnt_q;
  assign bus.op_err     = operr_q;

endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Built-in self-test sequencer for a single 2-input combinational gate (AND/OR/XOR/NAND/NOR/XNOR). On `start` it drives the gate's `A`/`B` inputs through all four input combinations in order 00, 01, 10, 11 and waits a programmable settle time on each. It then samples the gate output `Y` and compares it with the truth table of the selected operation. It sits beside the gate under test in the lab's gate-level designs and replaces per-vector checking done by hand in simulation with a synthesizable pass/fail result.

## Interface
- `SETTLE_CYCLES`, default 2, clock cycles each vector is held before `Y` is sampled; legal range 1..15.
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  begin a test run; sampled only in IDLE.
- `op`  input  3  gate selector: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; 6–7 illegal.
- `y`  input  1  output of the gate under test.
- `a`  output  1  driven to gate input `A` (vector bit 1).
- `b`  output  1  driven to gate input `B` (vector bit 0).
- `busy`  output  1  high while a run is in progress.
- `done`  output  1  one-cycle pulse when results are valid.
- `pass`  output  1  1 when the last run had zero mismatches and a legal op.
- `fail_mask`  output  4  bit k set when vector k (k = {a,b}) mismatched.
- `fail_count`  output  3  number of mismatching vectors, 0..4.
- `op_err`  output  1  last `start` carried an illegal `op`.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - On `start`=1 with a legal op: latch `op`, set vec=0, clear `fail_mask` and `fail_count`, clear `pass` and `op_err`, and go to SETTLE.
  - On `start`=1 with an illegal op: set `op_err`=1, `fail_mask`=4'b1111, `fail_count`=4, `pass`=0, and go to DONE.
- SETTLE:
  - `a`,`b` = vec[1], vec[0], registered and stable for the whole state.
  - A settle counter runs 0..SETTLE_CYCLES-1; on the last count, go to CHECK.
- CHECK:
  - Sample `y` and compare it with expected(op_latched, vec).
  - On mismatch, set `fail_mask[vec]` and increment `fail_count`.
  - If vec==3, go to DONE; otherwise vec increments and the FSM returns to SETTLE.
- DONE:
  - `done`=1 for exactly one cycle.
  - `pass` = (fail_count==0 && !op_err) after the final compare has been included.
  - Next state is IDLE.
- `start` while not in IDLE is ignored; it is not queued.
- `a`/`b` hold their last vector after a run; they return to 0 only on reset.
- `pass`, `fail_mask`, `fail_count` and `op_err` hold until the next accepted `start` or reset.
- Changes to `op` during a run have no effect, because the latched value is used.

## Timing
- Reset values:
  - State IDLE.
  - `a`=0, `b`=0.
  - `busy`=0, `done`=0, `pass`=0.
  - `fail_mask`=0, `fail_count`=0, `op_err`=0.
- Cycle numbering: `start` is accepted at cycle 0. `busy`=1 from cycle 1 through the last CHECK cycle, and is 0 in DONE.
- Vector k:
  - Is applied on `a`/`b` from cycle k·(S+1)+1, where S = SETTLE_CYCLES.
  - Is sampled in CHECK at cycle (k+1)·(S+1).
- `done` pulses at cycle 4·(S+1)+1; this is cycle 13 for S=2. `pass`/`fail_*` are valid in that same cycle.
- Illegal-op path: `done` pulses at cycle 1, and `busy` never asserts.
- Back-to-back runs: the earliest next `start` is accepted the cycle after DONE, i.e. the first IDLE cycle.
- Reset mid-run:
  - The FSM is in IDLE with all outputs at reset values on the cycle after `rst` is sampled high.
  - Partial results are discarded and no `done` is issued.
- Reset has priority over `start` in the same cycle.

## Structure
- Shared package `gate_pkg`:
  - Opcode constants OP_AND..OP_XNOR.
  - OP_LAST=5.
  - FSM state encoding.
  - Function `gate_expected(op, a, b)` returning the 1-bit truth-table value.
- One sub-module, `gate_ref_model`: combinational wrapper over `gate_expected`, reused as a golden model in other gate benches.
- Settle counter width: 4 bits.
- Vector counter: 2 bits. `fail_count`: 3 bits, saturating at 4 by construction.

## Test plan
- OR gate connected, `op`=1, S=2, `start` pulse → `a`/`b` sequence 00, 01, 10, 11; `done` at cycle 13; `pass`=1, `fail_mask`=0, `fail_count`=0.
- `y` tied to 0, `op`=1 → `pass`=0, `fail_mask`=4'b1110, `fail_count`=3; same result with `y` tied 0 and `op`=4 (NOR) gives `fail_mask`=4'b0001, `fail_count`=1.
- XNOR gate connected but `op`=2 (XOR) → `fail_mask`=4'b1111, `fail_count`=4, `pass`=0.
- `op`=7 with `start` → `done` at cycle 1, `op_err`=1, `fail_mask`=4'b1111, `busy` never high. A following legal run clears `op_err`.
- `rst` asserted at cycle 6 of a run → all outputs at reset values at cycle 7, no `done` pulse. A new `start` then runs to completion normally.
- `start` held high continuously with an AND gate, S=1 → runs repeat; each `done` at 4·2+1=9 cycles after acceptance, next run accepted at the following IDLE cycle. Toggling `op` mid-run does not change results.
